// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two clients (fetch, data), the arbiter and the downstream bridge.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface mem_arbiter_if;
    logic        i_request_enable;
    logic [31:0] i_req_addr;
    logic        i_response_enable;
    logic [31:0] i_resp_data;

    logic        d_request_enable;
    logic        d_req_mode;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_response_enable;
    logic [31:0] d_resp_data;

    logic        request_enable;
    logic        req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        response_enable;
    logic [31:0] resp_data;

    modport slave (
        input  i_request_enable, i_req_addr,
        output i_response_enable, i_resp_data,
        input  d_request_enable, d_req_mode, d_req_addr, d_req_wdata, d_req_wstrb,
        output d_response_enable, d_resp_data,
        output request_enable, req_mode, req_addr, req_wdata, req_wstrb,
        input  response_enable, resp_data
    );

    modport master (
        output i_request_enable, i_req_addr,
        input  i_response_enable, i_resp_data,
        output d_request_enable, d_req_mode, d_req_addr, d_req_wdata, d_req_wstrb,
        input  d_response_enable, d_resp_data,
        input  request_enable, req_mode, req_addr, req_wdata, req_wstrb,
        output response_enable, resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (fetch/data) arbiter in front of a single-outstanding downstream bridge.
// Each client holds one pending request; IDLE issues, BUSY waits, RESP is a guard cycle.
module mem_arbiter #(
    parameter bit FIXED_DPRIO = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    mem_arbiter_if.slave bus
);
    localparam logic MEMREQ_READ = 1'b0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic        i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    logic        last_q, last_d;
    logic        sel_data;

    logic [31:0] i_addr_q, i_addr_d;
    logic        d_mode_q, d_mode_d;
    logic [31:0] d_addr_q, d_addr_d;
    logic [31:0] d_wdata_q, d_wdata_d;
    logic [3:0]  d_wstrb_q, d_wstrb_d;

    logic        req_en_q, req_en_d;
    logic        req_mode_q, req_mode_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic        i_rsp_en_q, i_rsp_en_d;
    logic [31:0] i_rsp_data_q, i_rsp_data_d;
    logic        d_rsp_en_q, d_rsp_en_d;
    logic [31:0] d_rsp_data_q, d_rsp_data_d;

    always_comb begin
        state_d      = state_q;
        i_pend_d     = i_pend_q;
        d_pend_d     = d_pend_q;
        last_d       = last_q;
        sel_data     = 1'b0;
        i_addr_d     = i_addr_q;
        d_mode_d     = d_mode_q;
        d_addr_d     = d_addr_q;
        d_wdata_d    = d_wdata_q;
        d_wstrb_d    = d_wstrb_q;
        req_en_d     = 1'b0;
        req_mode_d   = req_mode_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wstrb_d  = req_wstrb_q;
        i_rsp_en_d   = 1'b0;
        i_rsp_data_d = i_rsp_data_q;
        d_rsp_en_d   = 1'b0;
        d_rsp_data_d = d_rsp_data_q;

        case (state_q)
            IDLE: begin
                if (i_pend_q || d_pend_q) begin
                    // On a tie, last_q = 0 (fetch) hands the grant to data.
                    if (i_pend_q && d_pend_q) sel_data = FIXED_DPRIO ? 1'b1 : ~last_q;
                    else                      sel_data = d_pend_q;
                    req_en_d = 1'b1;
                    if (sel_data) begin
                        req_mode_d  = d_mode_q;
                        req_addr_d  = d_addr_q;
                        req_wdata_d = d_wdata_q;
                        req_wstrb_d = d_wstrb_q;
                    end else begin
                        req_mode_d  = MEMREQ_READ;
                        req_addr_d  = i_addr_q;
                        req_wdata_d = 32'h0;
                        req_wstrb_d = 4'b0000;
                    end
                    last_d  = sel_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.response_enable) begin
                    if (last_q) begin
                        d_rsp_en_d   = 1'b1;
                        d_rsp_data_d = bus.resp_data;
                        d_pend_d     = 1'b0;
                    end else begin
                        i_rsp_en_d   = 1'b1;
                        i_rsp_data_d = bus.resp_data;
                        i_pend_d     = 1'b0;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Capture only into an empty slot; the served client's slot was cleared above
        // from its own registered flag, so the two never collide.
        if (bus.i_request_enable && !i_pend_q) begin
            i_pend_d = 1'b1;
            i_addr_d = bus.i_req_addr;
        end
        if (bus.d_request_enable && !d_pend_q) begin
            d_pend_d  = 1'b1;
            d_mode_d  = bus.d_req_mode;
            d_addr_d  = bus.d_req_addr;
            d_wdata_d = bus.d_req_wdata;
            d_wstrb_d = bus.d_req_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            i_pend_q     <= 1'b0;
            d_pend_q     <= 1'b0;
            last_q       <= 1'b0;
            req_en_q     <= 1'b0;
            req_mode_q   <= 1'b0;
            req_addr_q   <= 32'h0;
            req_wdata_q  <= 32'h0;
            req_wstrb_q  <= 4'b0000;
            i_rsp_en_q   <= 1'b0;
            i_rsp_data_q <= 32'h0;
            d_rsp_en_q   <= 1'b0;
            d_rsp_data_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            i_pend_q     <= i_pend_d;
            d_pend_q     <= d_pend_d;
            last_q       <= last_d;
            req_en_q     <= req_en_d;
            req_mode_q   <= req_mode_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_wstrb_q  <= req_wstrb_d;
            i_rsp_en_q   <= i_rsp_en_d;
            i_rsp_data_q <= i_rsp_data_d;
            d_rsp_en_q   <= d_rsp_en_d;
            d_rsp_data_q <= d_rsp_data_d;
        end
    end

    // Payload slots are qualified by the pending flags and need no reset.
    always_ff @(posedge clk) begin
        i_addr_q  <= i_addr_d;
        d_mode_q  <= d_mode_d;
        d_addr_q  <= d_addr_d;
        d_wdata_q <= d_wdata_d;
        d_wstrb_q <= d_wstrb_d;
    end

    assign bus.request_enable    = req_en_q;
    assign bus.req_mode          = req_mode_q;
    assign bus.req_addr          = req_addr_q;
    assign bus.req_wdata         = req_wdata_q;
    assign bus.req_wstrb         = req_wstrb_q;
    assign bus.i_response_enable = i_rsp_en_q;
    assign bus.i_resp_data       = i_rsp_data_q;
    assign bus.d_response_enable = d_rsp_en_q;
    assign bus.d_resp_data       = d_rsp_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin instance (bus) and one fixed-data-priority instance (bus2).
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    logic        got_ok;
    logic [68:0] got_req;
    int          got_issue;

    mem_arbiter_if bus ();
    mem_arbiter_if bus2 ();

    mem_arbiter #(.FIXED_DPRIO(1'b0)) dut_rr (.clk(clk), .rstn(rstn), .bus(bus.slave));
    mem_arbiter #(.FIXED_DPRIO(1'b1)) dut_fp (.clk(clk), .rstn(rstn), .bus(bus2.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit s, input bit fi, input bit fd, input logic [31:0] ia,
                         input logic dm, input logic [31:0] da, input logic [31:0] dw,
                         input logic [3:0] ds);
        if (s) begin
            bus2.i_request_enable = fi; bus2.i_req_addr = ia;
            bus2.d_request_enable = fd; bus2.d_req_mode = dm; bus2.d_req_addr = da;
            bus2.d_req_wdata = dw; bus2.d_req_wstrb = ds;
        end else begin
            bus.i_request_enable = fi; bus.i_req_addr = ia;
            bus.d_request_enable = fd; bus.d_req_mode = dm; bus.d_req_addr = da;
            bus.d_req_wdata = dw; bus.d_req_wstrb = ds;
        end
        tick();
        bus.i_request_enable = 1'b0;  bus.d_request_enable = 1'b0;
        bus2.i_request_enable = 1'b0; bus2.d_request_enable = 1'b0;
    endtask

    // Downstream model: wait (bounded) for a request, answer lat cycles later.
    // Returns in the cycle where the client response pulse should be visible.
    task automatic serve(input bit s, input int lat, input logic [31:0] rdata);
        got_ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if ((s ? bus2.request_enable : bus.request_enable) === 1'b1) begin
                got_ok = 1'b1;
                break;
            end
            tick();
        end
        if (got_ok) begin
            got_issue = cyc;
            got_req = s ? {bus2.req_mode, bus2.req_addr, bus2.req_wdata, bus2.req_wstrb}
                        : {bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb};
            repeat (lat) tick();
            if (s) begin bus2.response_enable = 1'b1; bus2.resp_data = rdata; end
            else   begin bus.response_enable  = 1'b1; bus.resp_data  = rdata; end
            tick();
            bus.response_enable = 1'b0; bus2.response_enable = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({bus.request_enable, bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb} !== 70'h0) begin
            n_fail++; $display("FAIL reset_req_rr: got %h want 0", {bus.request_enable, bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb});
        end
        n_cmp++;
        if ({bus.i_response_enable, bus.i_resp_data, bus.d_response_enable, bus.d_resp_data} !== 66'h0) begin
            n_fail++; $display("FAIL reset_resp_rr: got %h want 0", {bus.i_response_enable, bus.i_resp_data, bus.d_response_enable, bus.d_resp_data});
        end
        n_cmp++;
        if ({bus2.request_enable, bus2.req_mode, bus2.req_addr, bus2.req_wdata, bus2.req_wstrb,
             bus2.i_response_enable, bus2.i_resp_data, bus2.d_response_enable, bus2.d_resp_data} !== 136'h0) begin
            n_fail++; $display("FAIL reset_all_fp: outputs not all zero");
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_fetch_single();
        pulse(0, 1, 0, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 4'h0);
        n_cmp++;
        if (bus.request_enable !== 1'b0) begin n_fail++; $display("FAIL fetch_early_req: got %b want 0", bus.request_enable); end
        tick();
        n_cmp++;
        if (bus.request_enable !== 1'b1) begin n_fail++; $display("FAIL fetch_req_en: got %b want 1", bus.request_enable); end
        n_cmp++;
        if ({bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb} !== {1'b0, 32'h0000_1000, 32'h0, 4'h0}) begin
            n_fail++; $display("FAIL fetch_payload: got %h want %h", {bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb}, {1'b0, 32'h0000_1000, 32'h0, 4'h0});
        end
        tick();
        n_cmp++;
        if ({bus.request_enable, bus.req_addr} !== {1'b0, 32'h0000_1000}) begin
            n_fail++; $display("FAIL fetch_req_hold: got %h want %h", {bus.request_enable, bus.req_addr}, {1'b0, 32'h0000_1000});
        end
        tick(); tick(); tick();
        bus.response_enable = 1'b1; bus.resp_data = 32'hDEAD_BEEF;
        tick();
        bus.response_enable = 1'b0;
        n_cmp++;
        if ({bus.i_response_enable, bus.i_resp_data, bus.d_response_enable} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_fail++; $display("FAIL fetch_resp: got %h want %h", {bus.i_response_enable, bus.i_resp_data, bus.d_response_enable}, {1'b1, 32'hDEAD_BEEF, 1'b0});
        end
        tick();
        n_cmp++;
        if ({bus.i_response_enable, bus.d_response_enable} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_resp_pulse: got %b want 00", {bus.i_response_enable, bus.d_response_enable});
        end
        tick();
        n_cmp++;
        if (bus.request_enable !== 1'b0) begin n_fail++; $display("FAIL fetch_no_reissue: got %b want 0", bus.request_enable); end
    endtask

    task automatic test_data_write();
        int dcnt;
        pulse(0, 0, 1, 32'h0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
        serve(0, 2, 32'hCAFE_F00D);
        n_cmp++;
        if (got_ok !== 1'b1) begin n_fail++; $display("FAIL wr_timeout: got no request_enable"); end
        n_cmp++;
        if (got_req !== {1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011}) begin
            n_fail++; $display("FAIL wr_payload: got %h want %h", got_req, {1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011});
        end
        n_cmp++;
        if ({bus.d_response_enable, bus.d_resp_data, bus.i_response_enable, bus.i_resp_data} !== {1'b1, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL wr_resp: got %h want %h", {bus.d_response_enable, bus.d_resp_data, bus.i_response_enable, bus.i_resp_data}, {1'b1, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF});
        end
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.d_response_enable === 1'b1) dcnt++;
        end
        n_cmp++;
        if (dcnt != 0) begin n_fail++; $display("FAIL wr_extra_pulse: got %0d extra want 0", dcnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev_d;
        int first_issue;
        rstn = 1'b0; tick(); rstn = 1'b1; tick();
        for (int r = 0; r < 3; r++) begin
            pulse(0, 1, 1, 32'h0000_1000 + 32'(r * 16), 1'b0, 32'h9000_0000 + 32'(r), 32'h0, 4'h0);
            serve(0, 1, 32'hD000_0000 + 32'(r));
            first_issue = got_issue;
            n_cmp++;
            if ({got_ok, got_req} !== {1'b1, 1'b0, 32'h9000_0000 + 32'(r), 32'h0, 4'h0}) begin
                n_fail++; $display("FAIL rr_grant_data r%0d: got %h want %h", r, {got_ok, got_req}, {1'b1, 1'b0, 32'h9000_0000 + 32'(r), 32'h0, 4'h0});
            end
            n_cmp++;
            if ({bus.d_response_enable, bus.d_resp_data, bus.i_response_enable} !== {1'b1, 32'hD000_0000 + 32'(r), 1'b0}) begin
                n_fail++; $display("FAIL rr_route_data r%0d: got %h", r, {bus.d_response_enable, bus.d_resp_data, bus.i_response_enable});
            end
            prev_d = 32'hD000_0000 + 32'(r);
            serve(0, 1, 32'hF000_0000 + 32'(r));
            n_cmp++;
            if ({got_ok, got_req} !== {1'b1, 1'b0, 32'h0000_1000 + 32'(r * 16), 32'h0, 4'h0}) begin
                n_fail++; $display("FAIL rr_grant_fetch r%0d: got %h want %h", r, {got_ok, got_req}, {1'b1, 1'b0, 32'h0000_1000 + 32'(r * 16), 32'h0, 4'h0});
            end
            n_cmp++;
            if ({bus.i_response_enable, bus.i_resp_data, bus.d_response_enable, bus.d_resp_data} !== {1'b1, 32'hF000_0000 + 32'(r), 1'b0, prev_d}) begin
                n_fail++; $display("FAIL rr_route_fetch r%0d: got %h", r, {bus.i_response_enable, bus.i_resp_data, bus.d_response_enable, bus.d_resp_data});
            end
            n_cmp++;
            if (got_issue - first_issue != 4) begin
                n_fail++; $display("FAIL rr_throughput r%0d: got %0d cycles want 4", r, got_issue - first_issue);
            end
            tick();
        end
    endtask

    task automatic test_priority();
        logic [31:0] want;
        for (int s = 0; s < 2; s++) begin
            pulse(s[0], 0, 1, 32'h0, 1'b0, 32'h0000_A000, 32'h0, 4'h0);
            serve(s[0], 1, 32'h1);
            tick();
            pulse(s[0], 1, 1, 32'h0000_B000, 1'b0, 32'h0000_C000, 32'h0, 4'h0);
            serve(s[0], 1, 32'h2);
            want = (s == 1) ? 32'h0000_C000 : 32'h0000_B000;
            n_cmp++;
            if ({got_ok, got_req[67:36]} !== {1'b1, want}) begin
                n_fail++; $display("FAIL prio_first s%0d: got %h want %h", s, {got_ok, got_req[67:36]}, {1'b1, want});
            end
            serve(s[0], 1, 32'h3);
            want = (s == 1) ? 32'h0000_B000 : 32'h0000_C000;
            n_cmp++;
            if ({got_ok, got_req[67:36]} !== {1'b1, want}) begin
                n_fail++; $display("FAIL prio_second s%0d: got %h want %h", s, {got_ok, got_req[67:36]}, {1'b1, want});
            end
            tick();
        end
    endtask

    task automatic test_ignore_second();
        int icnt, rcnt;
        pulse(0, 1, 0, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 4'h0);
        pulse(0, 1, 0, 32'h0000_2000, 1'b0, 32'h0, 32'h0, 4'h0);
        serve(0, 3, 32'h55AA_55AA);
        n_cmp++;
        if ({got_ok, got_req[67:36]} !== {1'b1, 32'h0000_1000}) begin
            n_fail++; $display("FAIL ign_addr: got %h want %h", {got_ok, got_req[67:36]}, {1'b1, 32'h0000_1000});
        end
        icnt = (bus.i_response_enable === 1'b1) ? 1 : 0;
        rcnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.i_response_enable === 1'b1) icnt++;
            if (bus.request_enable === 1'b1) rcnt++;
        end
        n_cmp++;
        if (icnt != 1) begin n_fail++; $display("FAIL ign_resp_count: got %0d want 1", icnt); end
        n_cmp++;
        if (rcnt != 0) begin n_fail++; $display("FAIL ign_req_count: got %0d want 0", rcnt); end
    endtask

    task automatic test_reset_mid();
        int cnt;
        pulse(0, 1, 0, 32'h0000_6000, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        n_cmp++;
        if (bus.request_enable !== 1'b1) begin n_fail++; $display("FAIL rst_mid_issue: got %b want 1", bus.request_enable); end
        pulse(0, 0, 1, 32'h0, 1'b1, 32'h0000_7000, 32'hFFFF_FFFF, 4'hF);
        tick();
        rstn = 1'b0; tick(); rstn = 1'b1;
        n_cmp++;
        if ({bus.request_enable, bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb,
             bus.i_response_enable, bus.i_resp_data, bus.d_response_enable, bus.d_resp_data} !== 136'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", {bus.request_enable, bus.req_addr, bus.i_resp_data, bus.d_resp_data});
        end
        bus.response_enable = 1'b1; bus.resp_data = 32'hBAD0_BAD0;
        tick();
        bus.response_enable = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.i_response_enable === 1'b1 || bus.d_response_enable === 1'b1 || bus.request_enable === 1'b1) cnt++;
            tick();
        end
        n_cmp++;
        if (cnt != 0) begin n_fail++; $display("FAIL rst_mid_stray: got %0d active cycles want 0", cnt); end
        pulse(0, 1, 0, 32'h0000_3000, 1'b0, 32'h0, 32'h0, 4'h0);
        serve(0, 2, 32'h0F0F_0F0F);
        n_cmp++;
        if ({got_ok, got_req, bus.i_response_enable, bus.i_resp_data} !== {1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 1'b1, 32'h0F0F_0F0F}) begin
            n_fail++; $display("FAIL rst_mid_recover: got %h", {got_ok, got_req, bus.i_response_enable, bus.i_resp_data});
        end
        tick(); tick();
    endtask

    task automatic test_resp_capture();
        pulse(0, 1, 0, 32'h0000_4000, 1'b0, 32'h0, 32'h0, 4'h0);
        serve(0, 1, 32'h1111_0000);
        n_cmp++;
        if (bus.i_response_enable !== 1'b1) begin n_fail++; $display("FAIL cap_first_resp: got %b want 1", bus.i_response_enable); end
        pulse(0, 1, 0, 32'h0000_5000, 1'b0, 32'h0, 32'h0, 4'h0);
        n_cmp++;
        if (bus.request_enable !== 1'b0) begin n_fail++; $display("FAIL cap_idle_cycle: got %b want 0", bus.request_enable); end
        tick();
        n_cmp++;
        if ({bus.request_enable, bus.req_addr} !== {1'b1, 32'h0000_5000}) begin
            n_fail++; $display("FAIL cap_issue: got %h want %h", {bus.request_enable, bus.req_addr}, {1'b1, 32'h0000_5000});
        end
        serve(0, 1, 32'h2222_0000);
        n_cmp++;
        if ({bus.i_response_enable, bus.i_resp_data} !== {1'b1, 32'h2222_0000}) begin
            n_fail++; $display("FAIL cap_second_resp: got %h want %h", {bus.i_response_enable, bus.i_resp_data}, {1'b1, 32'h2222_0000});
        end
        tick();
    endtask

    initial begin
        bus.i_request_enable = 1'b0;  bus.i_req_addr = 32'h0;
        bus.d_request_enable = 1'b0;  bus.d_req_mode = 1'b0; bus.d_req_addr = 32'h0;
        bus.d_req_wdata = 32'h0;      bus.d_req_wstrb = 4'h0;
        bus.response_enable = 1'b0;   bus.resp_data = 32'h0;
        bus2.i_request_enable = 1'b0; bus2.i_req_addr = 32'h0;
        bus2.d_request_enable = 1'b0; bus2.d_req_mode = 1'b0; bus2.d_req_addr = 32'h0;
        bus2.d_req_wdata = 32'h0;     bus2.d_req_wstrb = 4'h0;
        bus2.response_enable = 1'b0;  bus2.resp_data = 32'h0;
        got_ok = 1'b0; got_req = '0; got_issue = 0;

        test_reset();
        test_fetch_single();
        test_data_write();
        test_back_to_back();
        test_priority();
        test_ignore_second();
        test_reset_mid();
        test_resp_capture();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_DPRIO, default 0; 0 = round-robin between the two clients, 1 = data client always wins ties.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 i_request_enable  in  1  instruction-fetch request pulse (read only).
REQ-005 i_req_addr  in  32  fetch address.
REQ-006 i_response_enable  out  1  one-cycle fetch response pulse.
REQ-007 i_resp_data  out  32  fetch read data.
REQ-008 d_request_enable  in  1  data request pulse.
REQ-009 d_req_mode  in  1  MEMREQ_READ / MEMREQ_WRITE (def.sv encoding).
REQ-010 d_req_addr, d_req_wdata  in  32 each  data address, write data.
REQ-011 d_req_wstrb  in  4  write byte strobes.
REQ-012 d_response_enable  out  1  one-cycle data response pulse.
REQ-013 d_resp_data  out  32  data read data (undefined content for writes).
REQ-014 request_enable  out  1  one-cycle request pulse to the downstream AXI bridge.
REQ-015 req_mode  out  1; req_addr, req_wdata  out  32; req_wstrb  out  4  downstream request payload.
REQ-016 response_enable  in  1; resp_data  in  32  downstream one-cycle response and data.

Function
REQ-017 Each client has a pending flag plus payload register; a request pulse sampled while that client's flag is clear sets the flag and captures the payload.
REQ-018 A request pulse sampled while the same client's flag is set shall be ignored (no payload overwrite).
REQ-019 Fetch requests shall be captured with mode MEMREQ_READ, wdata 0, wstrb 4'b0000.
REQ-020 States: IDLE, BUSY, RESP; exactly one downstream transaction outstanding at any time.
REQ-021 IDLE: if any pending flag is set at a clock edge, select one client, drive its payload onto req_*, assert request_enable for exactly that next cycle, record grant, go to BUSY.
REQ-022 Pending flags are visible to selection only from the edge after capture (request pulse to request_enable = 2 cycles minimum).
REQ-023 Selection: single pending client wins; both pending with FIXED_DPRIO=1 -> data; with FIXED_DPRIO=0 -> client not granted last.
REQ-024 req_* shall hold their values from issue until the transaction returns to IDLE.
REQ-025 BUSY: on response_enable=1, copy resp_data to the granted client's resp_data, pulse its response_enable for one cycle, clear its pending flag, go to RESP.
REQ-026 The non-granted client's response outputs and pending payload shall be unchanged by that response.
REQ-027 RESP: deassert client response pulse, go to IDLE; no request issued in RESP (guard cycle for downstream return to its idle state).
REQ-028 A request pulse from the just-served client during RESP shall be captured (its flag is already clear).
REQ-029 response_enable received in IDLE or RESP shall be ignored.
REQ-030 Back-to-back throughput: one downstream transaction per (downstream latency + 3) cycles.

Reset
REQ-031 rstn=0 at an edge: state IDLE, both pending flags clear, last grant = fetch, all outputs 0 (request_enable, req_mode, req_addr, req_wdata, req_wstrb, both response pulses, both resp_data).
REQ-032 Reset mid-transaction discards the outstanding request and all pending requests without a client response; a downstream response arriving after reset release in IDLE is ignored.

Verification
REQ-033 Fetch pulse addr 0x0000_1000 alone, downstream responds 0xDEADBEEF 4 cycles after request_enable -> request_enable 1 cycle, req_mode READ, wstrb 0; i_response_enable 1 cycle with 0xDEADBEEF; d_response_enable stays 0.
REQ-034 Data write addr 0x8000_0010, wdata 0x1234_5678, wstrb 4'b0011 -> req_* match exactly; d_response_enable pulses once after response_enable.
REQ-035 FIXED_DPRIO=0, both clients pulse same cycle, repeat 3 times -> grants data, fetch, data, fetch, data, fetch (reset last = fetch); each response routed to its owner only.
REQ-036 Second fetch pulse (addr 0x2000) while first (0x1000) pending -> only 0x1000 issued; exactly one i_response_enable.
REQ-037 rstn low for 1 cycle while BUSY with data pending -> all outputs 0; later stray response_enable produces no client pulse; next fetch request handled normally.
REQ-038 Fetch pulse during RESP after a fetch response -> captured and issued on the cycle after return to IDLE.
